// File: rtl/elvds_pkg.sv
// rtl/elvds_pkg.sv - shared state codes and frame-length helper for the ELVDS transmit scheduler
package elvds_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_TRAIL = 3'd5;
  localparam logic [2:0] ST_TURN  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LEAD  = ST_LEAD,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    TRAIL = ST_TRAIL,
    TURN  = ST_TURN
  } state_t;

  // Accept cycle + lead + start/data/stop + trail + turnaround.
  function automatic int FRAME_CYCLES(input int data_w, input int bit_div, input int guard);
    return 1 + 2 * guard + (data_w + 2) * bit_div + guard;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, purely combinational
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       winner
);

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    winner = (valid == 2'b11) ? ~last_grant : valid[1];
    grant  = 2'b00;
    if (enable && (valid != 2'b00)) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/elvds_tx_sched.sv
// rtl/elvds_tx_sched.sv - half-duplex framed byte scheduler driving an ELVDS_TBUF pair
module elvds_tx_sched
  import elvds_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_DIV = 4,
  parameter int GUARD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tbuf_i,
  output logic              tbuf_oen,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_MAX = (BIT_DIV > GUARD) ? BIT_DIV : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] BIT_RELOAD   = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_RELOAD = CNT_W'(GUARD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic              last_grant;
  logic [1:0]        grant;
  logic              winner;
  logic              accept;
  logic              cyc_done;

  // Grants are only offered from IDLE, never while reset is being applied.
  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     ((state == IDLE) && en && !rst),
    .grant      (grant),
    .winner     (winner)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign busy       = (state != IDLE);
  assign shift_nxt  = shift >> 1;
  assign cyc_done   = (cyc_cnt == '0);

  // Frame sequencer: line outputs are set together with the state they belong to,
  // so they change on the same edge the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      tbuf_oen   <= 1'b1;
      tbuf_i     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift      <= winner ? req1_data : req0_data;
            grant_id   <= winner;
            last_grant <= winner;
            state      <= LEAD;
            cyc_cnt    <= GUARD_RELOAD;
            tbuf_oen   <= 1'b0;
            tbuf_i     <= 1'b1;
          end
        end
        LEAD: begin
          if (cyc_done) begin
            state   <= START;
            cyc_cnt <= BIT_RELOAD;
            tbuf_i  <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        START: begin
          if (cyc_done) begin
            state   <= DATA;
            cyc_cnt <= BIT_RELOAD;
            bit_cnt <= LAST_BIT;
            tbuf_i  <= shift[0];
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        DATA: begin
          if (cyc_done) begin
            cyc_cnt <= BIT_RELOAD;
            if (bit_cnt == '0) begin
              state  <= STOP;
              tbuf_i <= 1'b1;
            end else begin
              shift   <= shift_nxt;
              tbuf_i  <= shift_nxt[0];
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        STOP: begin
          if (cyc_done) begin
            state   <= TRAIL;
            cyc_cnt <= GUARD_RELOAD;
            tbuf_i  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        TRAIL: begin
          if (cyc_done) begin
            state    <= TURN;
            cyc_cnt  <= GUARD_RELOAD;
            tbuf_oen <= 1'b1;
            tbuf_i   <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        TURN: begin
          if (cyc_done) begin
            state <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cyc_cnt  <= '0;
          tbuf_oen <= 1'b1;
          tbuf_i   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elvds_tx_sched.sv
// tb/tb_elvds_tx_sched.sv - self-checking bench for elvds_tx_sched
module tb_elvds_tx_sched;
  import elvds_pkg::*;

  localparam int D = 8;
  localparam int B = 4;
  localparam int G = 2;
  localparam int HN = 1024;

  logic       clk, rst, en;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       tbuf_i, tbuf_oen, busy, grant_id;

  logic       c_en, c_v0, c_v1, c_r0, c_r1, c_i, c_oen, c_busy, c_gid;
  logic [0:0] c_d0, c_d1;

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  int frame_p;

  logic h_oen [HN];
  logic h_i   [HN];
  logic h_r0  [HN];
  logic h_r1  [HN];
  logic h_busy[HN];
  logic h_gid [HN];
  logic ch_oen[HN];
  logic ch_i  [HN];
  logic ch_r0 [HN];

  elvds_tx_sched #(.DATA_W(8), .BIT_DIV(4), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tbuf_i(tbuf_i), .tbuf_oen(tbuf_oen), .busy(busy), .grant_id(grant_id)
  );

  elvds_tx_sched #(.DATA_W(1), .BIT_DIV(1), .GUARD(1)) dut_c (
    .clk(clk), .rst(rst), .en(c_en),
    .req0_valid(c_v0), .req0_data(c_d0), .req0_ready(c_r0),
    .req1_valid(c_v1), .req1_data(c_d1), .req1_ready(c_r1),
    .tbuf_i(c_i), .tbuf_oen(c_oen), .busy(c_busy), .grant_id(c_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected line pins at offset d (1..P-1) after the accept cycle, from the frame layout.
  function automatic void exp_line(input int d, input logic [7:0] b, output logic oen, output logic i);
    oen = 1'b0;
    i   = 1'b1;
    if (d <= G) i = 1'b1;
    else if (d <= G + B) i = 1'b0;
    else if (d <= G + B + D * B) i = b[(d - G - B - 1) / B];
    else if (d <= G + B + D * B + B + G) i = 1'b1;
    else oen = 1'b1;
  endfunction

  // Behavioural model: tracks frame offset, arbitration history and reset.
  logic       m_ok = 1'b0;
  logic       m_active = 1'b0;
  int         m_d = 0;
  logic [7:0] m_byte = '0;
  logic       m_last = 1'b1;
  logic       m_gid = 1'b0;

  always @(negedge clk) begin
    logic e_oen, e_i, e_r0, e_r1, win, anyv;
    if (cyc < HN) begin
      h_oen[cyc] = tbuf_oen; h_i[cyc] = tbuf_i; h_r0[cyc] = req0_ready;
      h_r1[cyc] = req1_ready; h_busy[cyc] = busy; h_gid[cyc] = grant_id;
      ch_oen[cyc] = c_oen; ch_i[cyc] = c_i; ch_r0[cyc] = c_r0;
    end
    anyv = req0_valid || req1_valid;
    win  = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e_r0 = !m_active && en && !rst && anyv && !win;
    e_r1 = !m_active && en && !rst && anyv && win;
    if (m_ok) begin
      if (m_active) exp_line(m_d, m_byte, e_oen, e_i);
      else begin e_oen = 1'b1; e_i = 1'b1; end
      chk("m_oen", tbuf_oen, e_oen);
      chk("m_i", tbuf_i, e_i);
      chk("m_busy", busy, m_active);
      chk("m_ready0", req0_ready, e_r0);
      chk("m_ready1", req1_ready, e_r1);
      chk("m_grant_id", grant_id, m_gid);
    end
    if (rst) begin
      m_ok = 1'b1; m_active = 1'b0; m_d = 0; m_last = 1'b1; m_gid = 1'b0;
    end else if (m_ok) begin
      if (e_r0 || e_r1) begin
        m_active = 1'b1; m_d = 1;
        m_byte = win ? req1_data : req0_data;
        m_last = win; m_gid = win;
      end else if (m_active) begin
        m_d++;
        if (m_d >= frame_p) m_active = 1'b0;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int t1, t2, t3, t4, t5;
    int bits_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int c_seq[5] = '{1, 0, 1, 1, 1};
    frame_p = FRAME_CYCLES(8, 4, 2);
    rst = 1'b1; en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    c_en = 1'b0; c_v0 = 1'b0; c_v1 = 1'b0; c_d0 = '0; c_d1 = '0;

    chk("frame_len_default", frame_p, 47);
    chk("frame_len_corner", FRAME_CYCLES(1, 1, 1), 7);

    goto(2);
    rst = 1'b0;
    chk("reset_oen", tbuf_oen, 1'b1);
    chk("reset_i", tbuf_i, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant_id", grant_id, 1'b0);
    chk("reset_c_oen", c_oen, 1'b1);

    // Single frame, req0 sends 0xA5; input changes after accept must not matter.
    en = 1'b1; req0_valid = 1'b1; req0_data = 8'hA5; t1 = cyc;
    goto(t1 + 1);
    req0_valid = 1'b0; req0_data = 8'hFF;
    goto(t1 + 48);
    for (int c = 1; c <= 44; c++) chk("t1_oen_low", h_oen[t1 + c], 1'b0);
    for (int c = 45; c <= 47; c++) chk("t1_oen_high", h_oen[t1 + c], 1'b1);
    for (int c = 3; c <= 6; c++) chk("t1_start", h_i[t1 + c], 1'b0);
    for (int k = 0; k < 8; k++)
      for (int s = 0; s < 4; s++) chk("t1_bit", h_i[t1 + 7 + 4 * k + s], bits_a5[k]);
    for (int c = 39; c <= 42; c++) chk("t1_stop", h_i[t1 + c], 1'b1);
    chk("t1_ready_at_accept", h_r0[t1], 1'b1);
    for (int c = 1; c <= 46; c++) chk("t1_ready_quiet", h_r0[t1 + c], 1'b0);

    // Contention after a fresh reset: req0 first, then alternate.
    rst = 1'b1;
    goto(cyc + 1);
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22; t2 = cyc;
    goto(t2 + 188);
    req0_valid = 1'b0; req1_valid = 1'b0;
    goto(t2 + 189);
    chk("t2_acc0_req0", h_r0[t2], 1'b1);
    chk("t2_acc1_req1", h_r1[t2 + 47], 1'b1);
    chk("t2_acc2_req0", h_r0[t2 + 94], 1'b1);
    chk("t2_acc3_req1", h_r1[t2 + 141], 1'b1);
    chk("t2_gid0", h_gid[t2 + 1], 1'b0);
    chk("t2_gid1", h_gid[t2 + 48], 1'b1);
    chk("t2_gid2", h_gid[t2 + 95], 1'b0);
    chk("t2_gid3", h_gid[t2 + 142], 1'b1);

    // Reset mid-frame at offset 20; both valid afterwards, req0 must win.
    t3 = cyc;
    req0_valid = 1'b1; req0_data = 8'h3C;
    goto(t3 + 1);
    req0_valid = 1'b0;
    goto(t3 + 20);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h96; req1_data = 8'h69;
    goto(t3 + 21);
    rst = 1'b0;
    goto(t3 + 22);
    req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b0;
    goto(t3 + 68);
    chk("t3_driving_before", h_oen[t3 + 20], 1'b0);
    chk("t3_no_ready_in_rst", h_r0[t3 + 20], 1'b0);
    chk("t3_oen_after", h_oen[t3 + 21], 1'b1);
    chk("t3_i_after", h_i[t3 + 21], 1'b1);
    chk("t3_busy_after", h_busy[t3 + 21], 1'b0);
    chk("t3_req0_wins", h_r0[t3 + 21], 1'b1);
    chk("t3_req1_loses", h_r1[t3 + 21], 1'b0);
    chk("t3_gid", h_gid[t3 + 22], 1'b0);
    chk("t3_restart", h_oen[t3 + 22], 1'b0);

    // en gating: grant only while en=1; frame completes after en drops.
    t4 = cyc;
    req1_valid = 1'b1; req1_data = 8'h5A;
    goto(t4 + 10);
    en = 1'b1;
    goto(t4 + 15);
    en = 1'b0;
    goto(t4 + 70);
    req1_valid = 1'b0;
    goto(t4 + 71);
    for (int c = 0; c <= 9; c++) begin
      chk("t4_gated_ready", h_r1[t4 + c], 1'b0);
      chk("t4_gated_oen", h_oen[t4 + c], 1'b1);
    end
    chk("t4_ready_on_en", h_r1[t4 + 10], 1'b1);
    chk("t4_oen_accept_cycle", h_oen[t4 + 10], 1'b1);
    chk("t4_oen_start", h_oen[t4 + 11], 1'b0);
    chk("t4_oen_trail", h_oen[t4 + 54], 1'b0);
    chk("t4_oen_turn", h_oen[t4 + 55], 1'b1);
    chk("t4_idle_busy", h_busy[t4 + 57], 1'b0);
    for (int c = 11; c <= 69; c++) chk("t4_no_regrant", h_r1[t4 + c], 1'b0);

    // Parameter corner 1/1/1 with byte 1.
    t5 = cyc;
    c_en = 1'b1; c_v0 = 1'b1; c_d0 = 1'b1;
    goto(t5 + 8);
    c_v0 = 1'b0;
    goto(t5 + 16);
    chk("c_accept", ch_r0[t5], 1'b1);
    for (int c = 1; c <= 5; c++) begin
      chk("c_oen_low", ch_oen[t5 + c], 1'b0);
      chk("c_i_seq", ch_i[t5 + c], c_seq[c - 1]);
    end
    chk("c_turn", ch_oen[t5 + 6], 1'b1);
    for (int c = 1; c <= 6; c++) chk("c_ready_quiet", ch_r0[t5 + c], 1'b0);
    chk("c_next_accept", ch_r0[t5 + 7], 1'b1);
    chk("c_next_frame", ch_oen[t5 + 8], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
